// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet frame constants and the TX payload buffer read-FSM encoding.
package eth_pkg;

  localparam int LEN_PERM    = 7;
  localparam int LEN_ADDR    = 6;
  localparam int LEN_LEN     = 2;
  localparam int LEN_CRC     = 4;
  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT   = 2'd1,
    RD_STREAM = 2'd2,
    RD_DONE   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/eth_sdp_ram.sv
// eth_sdp_ram: simple dual-port byte RAM, one write port and one registered read port.
module eth_sdp_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [1 << ADDR_W];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_tx_payload_buffer.sv
// eth_tx_payload_buffer: frame-aware TX payload store; commits whole frames, then streams them to the framer.
// Optional oversize-frame drop is compiled in with `define ETH_TXBUF_DROP_OVERSIZE_EN.
module eth_tx_payload_buffer
  import eth_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int LEN_FIFO_W  = 3,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  data_recive,
  output logic                  buffer_ready,
  output logic                  read_en,
  output logic [7:0]            data_out,
  output logic                  buffer_empt,
  output logic [LEN_FIFO_W:0]   frames_pend
);

  localparam int LEN_W    = ADDR_W + 1;
  localparam int LF_DEPTH = 1 << LEN_FIFO_W;

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   commit_ptr_q, commit_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [LEN_W-1:0]    cur_len_q, cur_len_d;
  logic                up_q;
  logic                ram_full, lf_full, lf_empty;
  logic                accept, commit, ram_we, frame_bad;

  logic [LEN_W-1:0]    lf_mem_q [LF_DEPTH];
  logic [LEN_FIFO_W:0] lf_wr_q, lf_rd_q;
  logic                lf_pop;

  rd_state_e           rd_state_q;
  logic [LEN_W-1:0]    rd_left_q;
  logic                rd_issue, rd_exit;
  logic                buf_ready_q, rd_vld_q, empt_q;
  logic [LEN_FIFO_W:0] frames_pend_q;
  logic [7:0]          ram_rdata;

  // One RAM slot is always left empty so full and empty pointers never coincide.
  assign ram_full = ((wr_ptr_q + ADDR_W'(1)) == rd_ptr_q);
  assign lf_empty = (lf_wr_q == lf_rd_q);
  assign lf_full  = (lf_wr_q[LEN_FIFO_W] != lf_rd_q[LEN_FIFO_W]) &&
                    (lf_wr_q[LEN_FIFO_W-1:0] == lf_rd_q[LEN_FIFO_W-1:0]);

  assign s_ready = up_q && !ram_full && !lf_full;
  assign accept  = s_valid && s_ready;

`ifdef ETH_TXBUF_DROP_OVERSIZE_EN
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  logic        bad_q;
  logic [15:0] drop_cnt_q;

  // Any byte arriving once MAX_LEN bytes are held condemns the frame; the rest is swallowed.
  assign frame_bad = bad_q || (cur_len_q >= MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q      <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else if (accept) begin
      bad_q <= frame_bad && !s_last;
      if (frame_bad && s_last && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  logic cfg_unused;

  assign frame_bad  = 1'b0;
  assign cfg_unused = (MAX_PAYLOAD > 0);
`endif

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cur_len_d    = cur_len_q;
    ram_we       = 1'b0;
    commit       = 1'b0;
    if (accept) begin
      if (frame_bad) begin
        if (s_last) begin
          wr_ptr_d  = commit_ptr_q;
          cur_len_d = '0;
        end else begin
          cur_len_d = cur_len_q + LEN_W'(1);
        end
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (s_last) begin
          commit       = 1'b1;
          commit_ptr_d = wr_ptr_q + ADDR_W'(1);
          cur_len_d    = '0;
        end else begin
          cur_len_d = cur_len_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q         <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cur_len_q    <= '0;
    end else begin
      up_q         <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cur_len_q    <= cur_len_d;
    end
  end

  // Length FIFO: the stored length includes the s_last byte itself.
  always_ff @(posedge clk) begin
    if (commit) lf_mem_q[lf_wr_q[LEN_FIFO_W-1:0]] <= cur_len_q + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_wr_q <= '0;
      lf_rd_q <= '0;
    end else begin
      if (commit) lf_wr_q <= lf_wr_q + (LEN_FIFO_W+1)'(1);
      if (lf_pop) lf_rd_q <= lf_rd_q + (LEN_FIFO_W+1)'(1);
    end
  end

  assign lf_pop   = (rd_state_q == RD_IDLE) && !lf_empty;
  assign rd_issue = (rd_state_q == RD_STREAM) && (rd_left_q != '0);
  assign rd_exit  = (rd_state_q == RD_DONE);

  // STREAM spends one extra cycle after the last address so buffer_empt trails the last read_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q  <= RD_IDLE;
      rd_left_q   <= '0;
      rd_ptr_q    <= '0;
      buf_ready_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      empt_q      <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      empt_q   <= 1'b0;
      case (rd_state_q)
        RD_IDLE: begin
          if (!lf_empty) begin
            rd_left_q   <= lf_mem_q[lf_rd_q[LEN_FIFO_W-1:0]];
            buf_ready_q <= 1'b1;
            rd_state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (data_recive) begin
            buf_ready_q <= 1'b0;
            rd_state_q  <= RD_STREAM;
          end
        end
        RD_STREAM: begin
          if (rd_left_q != '0) begin
            rd_left_q <= rd_left_q - LEN_W'(1);
            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
          end else begin
            empt_q     <= 1'b1;
            rd_state_q <= RD_DONE;
          end
        end
        RD_DONE: rd_state_q <= RD_IDLE;
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_pend_q <= '0;
    end else begin
      case ({commit, rd_exit})
        2'b10:   frames_pend_q <= frames_pend_q + (LEN_FIFO_W+1)'(1);
        2'b01:   frames_pend_q <= frames_pend_q - (LEN_FIFO_W+1)'(1);
        default: frames_pend_q <= frames_pend_q;
      endcase
    end
  end

  eth_sdp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign buffer_ready = buf_ready_q;
  assign read_en      = rd_vld_q;
  assign data_out     = rd_vld_q ? ram_rdata : 8'h00;
  assign buffer_empt  = empt_q;
  assign frames_pend  = frames_pend_q;

endmodule

// File: tb/tb_eth_tx_payload_buffer.sv
// Scoreboard bench for eth_tx_payload_buffer: a default-size instance and a 16-byte instance with MAX_PAYLOAD=8.
module tb_eth_tx_payload_buffer;

`ifdef ETH_TXBUF_DROP_OVERSIZE_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] a_s_data, b_s_data, a_data_out, b_data_out;
  logic a_s_valid, a_s_last, a_s_ready, a_data_recive, a_buffer_ready, a_read_en, a_buffer_empt;
  logic b_s_valid, b_s_last, b_s_ready, b_data_recive, b_buffer_ready, b_read_en, b_buffer_empt;
  logic [3:0] a_frames_pend, b_frames_pend;

  int n_vec = 0;
  int n_bad = 0;
  int seen_a = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  eth_tx_payload_buffer #(.ADDR_W(11), .LEN_FIFO_W(3), .MAX_PAYLOAD(1500)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid), .s_last(a_s_last),
    .s_ready(a_s_ready), .data_recive(a_data_recive), .buffer_ready(a_buffer_ready),
    .read_en(a_read_en), .data_out(a_data_out), .buffer_empt(a_buffer_empt),
    .frames_pend(a_frames_pend));

  eth_tx_payload_buffer #(.ADDR_W(4), .LEN_FIFO_W(3), .MAX_PAYLOAD(8)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last),
    .s_ready(b_s_ready), .data_recive(b_data_recive), .buffer_ready(b_buffer_ready),
    .read_en(b_read_en), .data_out(b_data_out), .buffer_empt(b_buffer_empt),
    .frames_pend(b_frames_pend));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // Monitor side: every read_en byte and every buffer_empt pulse is one scoreboard event.
  task automatic mon_event(input bit b, input logic [8:0] got, input string nm);
    logic [8:0] e;
    n_vec++;
    if ((b ? qb.size() : qa.size()) == 0) begin
      n_bad++;
      $display("FAIL %s: got %03h, required no output", nm, got);
    end else begin
      if (b) e = qb.pop_front();
      else   e = qa.pop_front();
      if (e !== got) begin
        n_bad++;
        $display("FAIL %s: got %03h, required %03h", nm, got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_read_en === 1'b1) begin
      mon_event(1'b0, {1'b0, a_data_out}, "a_byte");
      seen_a++;
    end
    if (a_buffer_empt === 1'b1) mon_event(1'b0, 9'h100, "a_empt");
    if (b_read_en === 1'b1)     mon_event(1'b1, {1'b0, b_data_out}, "b_byte");
    if (b_buffer_empt === 1'b1) mon_event(1'b1, 9'h100, "b_empt");
  end

  task automatic exp_frame(input bit b, input logic [7:0] base, input int len, input logic [7:0] step);
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      v = base + step * 8'(i);
      if (b) qb.push_back({1'b0, v});
      else   qa.push_back({1'b0, v});
    end
    if (b) qb.push_back(9'h100);
    else   qa.push_back(9'h100);
  endtask

  task automatic push(input bit b, input logic [7:0] d, input bit last);
    bit ok = 1'b0;
    int n  = 0;
    if (b) begin b_s_data = d; b_s_last = last; b_s_valid = 1'b1; end
    else   begin a_s_data = d; a_s_last = last; a_s_valid = 1'b1; end
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = b ? b_s_ready : a_s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (b) begin b_s_valid = 1'b0; b_s_last = 1'b0; end
    else   begin a_s_valid = 1'b0; a_s_last = 1'b0; end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: byte %02h not accepted, required accept within 400 cycles", d);
    end
  endtask

  task automatic send_frame(input bit b, input logic [7:0] base, input int len,
                            input logic [7:0] step, input bit exp_en);
    if (exp_en) exp_frame(b, base, len, step);
    for (int i = 0; i < len; i++) push(b, base + step * 8'(i), i == len - 1);
  endtask

  task automatic wait_drain(input bit b, input string nm);
    int n = 0;
    while ((b ? qb.size() : qa.size()) != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 32'(b ? qb.size() : qa.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_seen;
    int n;
    rst_n = 1'b0;
    a_s_data = 8'h00; a_s_valid = 1'b0; a_s_last = 1'b0; a_data_recive = 1'b0;
    b_s_data = 8'h00; b_s_valid = 1'b0; b_s_last = 1'b0; b_data_recive = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_s_ready", 32'(a_s_ready), 0);
    check("rst_a_buffer_ready", 32'(a_buffer_ready), 0);
    check("rst_a_read_en", 32'(a_read_en), 0);
    check("rst_a_data_out", 32'(a_data_out), 0);
    check("rst_a_buffer_empt", 32'(a_buffer_empt), 0);
    check("rst_a_frames_pend", 32'(a_frames_pend), 0);
    check("rst_b_s_ready", 32'(b_s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s_ready_before_clk", 32'(a_s_ready), 0);
    @(posedge clk); #1;
    check("a_s_ready_after_clk", 32'(a_s_ready), 1);
    check("b_s_ready_after_clk", 32'(b_s_ready), 1);

    // 3-byte frame AA,BB,CC with the framer already requesting.
    a_data_recive = 1'b1;
    send_frame(1'b0, 8'hAA, 3, 8'h11, 1'b1);
    wait_drain(1'b0, "t1_drain");
    check("t1_frames_pend", 32'(a_frames_pend), 0);

    // Two 60-byte frames held back, then released.
    a_data_recive = 1'b0;
    send_frame(1'b0, 8'h01, 60, 8'h01, 1'b1);
    send_frame(1'b0, 8'h80, 60, 8'h01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t2_frames_pend", 32'(a_frames_pend), 2);
    check("t2_buffer_ready", 32'(a_buffer_ready), 1);
    a_data_recive = 1'b1;
    wait_drain(1'b0, "t2_drain");
    check("t2_frames_pend_end", 32'(a_frames_pend), 0);

    // Asynchronous reset in the middle of a 40-byte burst.
    base_seen = seen_a;
    send_frame(1'b0, 8'hC0, 40, 8'h01, 1'b1);
    n = 0;
    while (seen_a < base_seen + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_byte10", 32'(seen_a >= base_seen + 10), 1);
    #2;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check("t4_read_en", 32'(a_read_en), 0);
    check("t4_data_out", 32'(a_data_out), 0);
    check("t4_buffer_ready", 32'(a_buffer_ready), 0);
    check("t4_buffer_empt", 32'(a_buffer_empt), 0);
    check("t4_frames_pend", 32'(a_frames_pend), 0);
    check("t4_s_ready", 32'(a_s_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, 8'h50, 5, 8'h03, 1'b1);
    wait_drain(1'b0, "t4_post_drain");
    check("t4_post_frames_pend", 32'(a_frames_pend), 0);

    // Oversize handling on the small instance: 10-byte frame then 4-byte frame.
    b_data_recive = 1'b0;
    send_frame(1'b1, 8'h10, 10, 8'h01, !DROP);
    check("t5_pend_after_10", 32'(b_frames_pend), DROP ? 32'd0 : 32'd1);
    send_frame(1'b1, 8'h40, 4, 8'h01, 1'b1);
    check("t5_pend_after_4", 32'(b_frames_pend), DROP ? 32'd1 : 32'd2);
`ifdef ETH_TXBUF_DROP_OVERSIZE_EN
    check("t5_drop_cnt", 32'(u_b.drop_cnt_q), 1);
`endif
    b_data_recive = 1'b1;
    wait_drain(1'b1, "t5_drain");
    check("t5_frames_pend_end", 32'(b_frames_pend), 0);

    // RAM-full stall across the pointer wrap on the 16-byte instance.
    b_data_recive = 1'b0;
    send_frame(1'b1, 8'hA0, 8, 8'h01, 1'b1);
    exp_frame(1'b1, 8'hB0, 8, 8'h01);
    for (int i = 0; i < 7; i++) push(1'b1, 8'hB0 + 8'(i), 1'b0);
    check("t3_s_ready_full", 32'(b_s_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_s_ready_still_full", 32'(b_s_ready), 0);
    b_data_recive = 1'b1;
    push(1'b1, 8'hB7, 1'b1);
    wait_drain(1'b1, "t3_drain");
    check("t3_frames_pend_end", 32'(b_frames_pend), 0);
    check("t3_s_ready_end", 32'(b_s_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
